// File: rtl/sprite_fetch.sv
// Sprite pixel fetch: 3-stage pipeline that turns a sprite (element, address) hit into a
// memory read and a DAC colour, keeping syncs aligned and counting opaque pixels per frame.
module sprite_fetch #(
    parameter int         ELEMENT = 5,
    parameter logic [8:0] TRANSP  = 9'h1C7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               ready,
    input  logic [ELEMENT-1:0] element,
    input  logic [9:0]         address,
    input  logic [8:0]         bg_color,
    input  logic               frame_start,
    output logic [13:0]        mem_addr,
    output logic               mem_rd,
    input  logic [8:0]         mem_data,
    output logic [8:0]         rgb,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [15:0]        hits_last
);

    logic [13:0] fetch_addr;
    logic        fetch_hit;
    logic [2:1]  vld_pipe;
    logic [2:0]  hs_pipe;
    logic [2:0]  vs_pipe;
    logic [8:0]  data_s2;
    logic        hit_s2;
    logic        opaque;
    logic [15:0] hit_cnt;
    logic [15:0] cnt_next;

    assign fetch_addr = 14'(element) * 14'd400 + 14'(address);
    assign fetch_hit  = ready & active & (address < 10'd400);

    assign opaque   = hit_s2 & vld_pipe[2] & (data_s2 != TRANSP);
    assign cnt_next = (opaque && hit_cnt != 16'hFFFF) ? hit_cnt + 16'd1 : hit_cnt;

    assign hsync_o = hs_pipe[2];
    assign vsync_o = vs_pipe[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            vld_pipe  <= '0;
            hs_pipe   <= '1;
            vs_pipe   <= '1;
            data_s2   <= '0;
            hit_s2    <= 1'b0;
            rgb       <= '0;
            hit_cnt   <= '0;
            hits_last <= '0;
        end else begin
            // Stage 1: address generation; a miss parks the address at 0
            mem_rd   <= fetch_hit;
            mem_addr <= fetch_hit ? fetch_addr : 14'd0;
            vld_pipe <= {vld_pipe[1], active};
            hs_pipe  <= {hs_pipe[1:0], hsync};
            vs_pipe  <= {vs_pipe[1:0], vsync};

            // Stage 2: memory answers one cycle after the read strobe
            data_s2 <= mem_data;
            hit_s2  <= mem_rd;

            // Stage 3: colour select; bg_color is quasi-static so it is taken live here
            if (!vld_pipe[2])
                rgb <= '0;
            else if (opaque)
                rgb <= data_s2;
            else
                rgb <= bg_color;

            // frame_start acts on the stage-3 pixel of the same cycle, so its hit is included
            if (frame_start) begin
                hits_last <= cnt_next;
                hit_cnt   <= '0;
            end else begin
                hit_cnt <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch: stimulus pushes expected stage-1 and stage-3 results into
// queues, a monitor pops and compares them at the matching latency.
module tb_sprite_fetch;

    localparam logic [8:0] TR = 9'h1C7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        active = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        ready = 1'b0;
    logic [4:0]  element = '0;
    logic [9:0]  address = '0;
    logic [8:0]  bg_color = 9'h038;
    logic        frame_start = 1'b0;
    logic [13:0] mem_addr;
    logic        mem_rd;
    logic [8:0]  mem_data;
    logic [8:0]  rgb;
    logic        hsync_o;
    logic        vsync_o;
    logic [15:0] hits_last;

    sprite_fetch dut (
        .clk(clk), .reset(reset), .active(active), .hsync(hsync), .vsync(vsync),
        .ready(ready), .element(element), .address(address), .bg_color(bg_color),
        .frame_start(frame_start), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .hits_last(hits_last)
    );

    always #5 clk = ~clk;

    // Sprite memory: data valid in the cycle after the registered read strobe
    logic [8:0] mem [0:12799];
    assign mem_data = mem_rd ? mem[mem_addr] : 9'h000;

    typedef struct packed { logic [8:0] rgb; logic hs; logic vs; } pix_t;
    typedef struct packed { logic rd; logic [13:0] addr; } rd_t;

    pix_t pq[$];
    rd_t  rq[$];
    pix_t pe;
    rd_t  re;
    int   checks = 0;
    int   errors = 0;
    int   opaque_cnt = 0;
    logic issuing = 1'b0;
    logic [2:0] dly;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset)
        if (!reset) dly <= '0;
        else        dly <= {dly[1:0], issuing};

    // Monitor: stage-1 results one edge after sampling, colour/syncs three edges after
    always @(negedge clk) begin
        if (dly[0]) begin
            if (rq.size() == 0) chk("rd_queue_empty", 32'd1, 32'd0);
            else begin
                re = rq.pop_front();
                chk("mem_rd", {31'd0, mem_rd}, {31'd0, re.rd});
                chk("mem_addr", {18'd0, mem_addr}, {18'd0, re.addr});
            end
        end
        if (dly[2]) begin
            if (pq.size() == 0) chk("pix_queue_empty", 32'd1, 32'd0);
            else begin
                pe = pq.pop_front();
                chk("rgb", {23'd0, rgb}, {23'd0, pe.rgb});
                chk("hsync_o", {31'd0, hsync_o}, {31'd0, pe.hs});
                chk("vsync_o", {31'd0, vsync_o}, {31'd0, pe.vs});
            end
        end
    end

    task automatic pix(input logic act, input logic rdy, input logic [4:0] el,
                       input logic [9:0] ad, input logic hs, input logic vs, input logic fs);
        logic        rd;
        logic [13:0] a;
        logic [8:0]  e;
        @(posedge clk); #1;
        active = act; ready = rdy; element = el; address = ad;
        hsync = hs; vsync = vs; frame_start = fs; issuing = 1'b1;
        rd = rdy & act & (ad < 10'd400);
        a  = rd ? 14'(el) * 14'd400 + 14'(ad) : 14'd0;
        rq.push_back('{rd: rd, addr: a});
        if (!act) e = 9'h000;
        else if (rd && mem[a] != TR) begin e = mem[a]; opaque_cnt++; end
        else e = bg_color;
        pq.push_back('{rgb: e, hs: hs, vs: vs});
    endtask

    task automatic idle(input int n, input logic fs);
        for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 5'd0, 10'd0, 1'b1, 1'b1, fs);
    endtask

    task automatic outs_reset(input string tag);
        chk({tag, "_rgb"}, {23'd0, rgb}, 32'd0);
        chk({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
        chk({tag, "_mem_addr"}, {18'd0, mem_addr}, 32'd0);
        chk({tag, "_hsync_o"}, {31'd0, hsync_o}, 32'd1);
        chk({tag, "_vsync_o"}, {31'd0, vsync_o}, 32'd1);
        chk({tag, "_hits_last"}, {16'd0, hits_last}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 12800; i++) begin
            mem[i] = 9'(i * 5 + 3);
            if (mem[i] == TR) mem[i] = 9'h000;
        end
        mem[815]   = 9'h0A5;
        mem[816]   = TR;
        mem[12799] = 9'h155;

        #12;
        outs_reset("por");
        @(posedge clk); #1 reset = 1'b1;

        // Basic fetch, transparent pixel, out-of-range address, inactive with sync toggle
        pix(1'b1, 1'b1, 5'd2, 10'd15, 1'b1, 1'b1, 1'b0);
        pix(1'b1, 1'b1, 5'd2, 10'd16, 1'b1, 1'b1, 1'b0);
        pix(1'b1, 1'b1, 5'd2, 10'd400, 1'b1, 1'b1, 1'b0);
        pix(1'b0, 1'b1, 5'd2, 10'd15, 1'b0, 1'b1, 1'b0);
        pix(1'b1, 1'b0, 5'd7, 10'd20, 1'b0, 1'b0, 1'b0);
        // Back-to-back distinct fetches, extreme address
        pix(1'b1, 1'b1, 5'd31, 10'd399, 1'b1, 1'b0, 1'b0);
        pix(1'b1, 1'b1, 5'd0, 10'd0, 1'b1, 1'b1, 1'b0);
        pix(1'b1, 1'b1, 5'd3, 10'd100, 1'b0, 1'b1, 1'b0);
        pix(1'b1, 1'b1, 5'd3, 10'd1023, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b0);
        bg_color = 9'h1A2;
        pix(1'b1, 1'b1, 5'd4, 10'd500, 1'b1, 1'b1, 1'b0);
        pix(1'b1, 1'b1, 5'd2, 10'd16, 1'b1, 1'b1, 1'b0);
        pix(1'b1, 1'b1, 5'd2, 10'd15, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b0);

        // Close the frame with nothing opaque in flight
        idle(1, 1'b1);
        idle(1, 1'b0);
        chk("hits_last_first_frame", {16'd0, hits_last}, 32'(opaque_cnt));

        // 10 opaque hits, then frame_start lands on the 11th at stage 3
        for (int i = 0; i < 11; i++) pix(1'b1, 1'b1, 5'd1, 10'(i), 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        chk("hits_last_11", {16'd0, hits_last}, 32'd11);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        chk("hits_last_cleared", {16'd0, hits_last}, 32'd0);

        // Saturation: preload the counter, then one more opaque hit
        @(negedge clk);
        force dut.hit_cnt = 16'hFFFF;
        idle(1, 1'b0);
        @(negedge clk);
        release dut.hit_cnt;
        pix(1'b1, 1'b1, 5'd5, 10'd7, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        chk("hits_last_saturated", {16'd0, hits_last}, 32'h0000FFFF);

        // Mid-stream reset: clears immediately, in-flight pixels are dropped
        pix(1'b1, 1'b1, 5'd2, 10'd15, 1'b0, 1'b0, 1'b0);
        pix(1'b1, 1'b1, 5'd6, 10'd33, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0; issuing = 1'b0;
        active = 1'b0; ready = 1'b0; hsync = 1'b1; vsync = 1'b1;
        #1;
        outs_reset("midrst");
        pq.delete(); rq.delete();
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        pix(1'b1, 1'b1, 5'd2, 10'd15, 1'b0, 1'b1, 1'b0);
        pix(1'b1, 1'b1, 5'd9, 10'd250, 1'b1, 1'b0, 1'b0);
        pix(1'b0, 1'b1, 5'd9, 10'd251, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        @(posedge clk); #1 issuing = 1'b0;
        repeat (4) @(posedge clk);
        chk("queues_drained", 32'(pq.size() + rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
